// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared state type, Gray helpers and default widths for the ring oscillator meter
package ring_osc_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_RESULT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } meter_state_t;

  // Fixed 32-bit helpers; callers zero-extend narrower words, which leaves the low bits unchanged.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ring_gray_counter.sv
// rtl/ring_gray_counter.sv - ring-domain edge counter with registered Gray output
module ring_gray_counter
  import ring_osc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             ring_clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] gray
);

  logic [CNT_W-1:0] bin_q;
  logic [CNT_W-1:0] bin_nxt;

  assign bin_nxt = bin_q + CNT_W'(1);

  // Gray is registered so only one bit can change per ring edge as seen by the clk domain.
  always_ff @(posedge ring_clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      gray  <= '0;
    end else begin
      bin_q <= bin_nxt;
      gray  <= CNT_W'(bin2gray(32'(bin_nxt)));
    end
  end

endmodule

// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - gated ring oscillator frequency meter; RING_FREQ_MINMAX_EN adds min/max tracking
module ring_osc_freq_meter
  import ring_osc_pkg::*;
#(
  parameter int GATE_CYCLES   = 4096,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RESULT_W      = DEF_RESULT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ring_clk,
  output logic                osc_en,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [RESULT_W-1:0] result,
  output logic                result_sat,
  output logic                overrun
`ifdef RING_FREQ_MINMAX_EN
  ,
  output logic [RESULT_W-1:0] min_result,
  output logic [RESULT_W-1:0] max_result
`endif
);

  localparam int SUM_W = ((RESULT_W > CNT_W) ? RESULT_W : CNT_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({RESULT_W{1'b1}});

  meter_state_t state_q, state_d;
  logic [31:0] cyc_q, cyc_d;
  logic run_q;

  logic [CNT_W-1:0] ring_gray, sync1_q, sync2_q, cur_bin, prev_q, delta;
  logic [RESULT_W-1:0] acc_q;
  logic sat_q;
  logic [SUM_W-1:0] sum;
  logic start_go, done_load;

  ring_gray_counter #(.CNT_W(CNT_W)) u_ring_cnt (
    .ring_clk(ring_clk),
    .rst_n   (rst_n),
    .gray    (ring_gray)
  );

  assign cur_bin   = CNT_W'(gray2bin(32'(sync2_q)));
  assign delta     = cur_bin - prev_q;
  assign sum       = SUM_W'(acc_q) + SUM_W'(delta);
  assign start_go  = (state_q == ST_IDLE) && start && !stop;
  assign done_load = (state_q == ST_DONE) && !stop;
  assign osc_en    = run_q;
  assign busy      = run_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    if (stop) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SETTLE;
            cyc_d   = '0;
          end
        end
        ST_SETTLE: begin
          if (cyc_q == 32'(SETTLE_CYCLES - 1)) begin
            state_d = ST_MEASURE;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        ST_MEASURE: begin
          if (cyc_q == 32'(GATE_CYCLES - 1)) begin
            state_d = ST_DONE;
            cyc_d   = '0;
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        ST_DONE: begin
          state_d = continuous ? ST_MEASURE : ST_IDLE;
          cyc_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cyc_d   = '0;
        end
      endcase
    end
  end

  // osc_en comes from a flop so the ring gate never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      run_q   <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      sync1_q <= ring_gray;
      sync2_q <= sync1_q;
      prev_q  <= cur_bin;
      if (state_q == ST_MEASURE) begin
        if (sum > ACC_MAX) begin
          acc_q <= '1;
          sat_q <= 1'b1;
        end else begin
          acc_q <= sum[RESULT_W-1:0];
        end
      end else begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_sat   <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (done_load) begin
      result       <= acc_q;
      result_sat   <= sat_q;
      result_valid <= 1'b1;
      if (result_valid && !result_ready) begin
        overrun <= 1'b1;
      end
    end else begin
      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if (start_go) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef RING_FREQ_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_result <= '0;
      max_result <= '0;
    end else if (start_go) begin
      min_result <= '1;
      max_result <= '0;
    end else if (done_load) begin
      if (acc_q < min_result) min_result <= acc_q;
      if (acc_q > max_result) max_result <= acc_q;
    end
  end
`endif

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// tb/tb_ring_osc_freq_meter.sv - scoreboard bench for ring_osc_freq_meter; RING_FREQ_MINMAX_EN adds min/max checks
module tb_ring_osc_freq_meter;

  localparam int CLK_P    = 10;
  localparam int GATE     = 300;
  localparam int SETTLE   = 8;
  localparam int RW       = 24;
  localparam int GATE_S   = 200;
  localparam int SETTLE_S = 4;
  localparam int RW_S     = 6;

  typedef struct {
    int lo;
    int hi;
    bit sat;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, ring_clk = 1'b0, ring_s = 1'b0;
  logic start = 1'b0, stop = 1'b0, continuous = 1'b0, result_ready = 1'b1;
  logic osc_en, busy, result_valid, result_sat, overrun;
  logic [RW-1:0] result;
  logic start_s = 1'b0;
  logic osc_en_s, busy_s, result_valid_s, result_sat_s, overrun_s;
  logic [RW_S-1:0] result_s;
`ifdef RING_FREQ_MINMAX_EN
  logic [RW-1:0] min_result, max_result;
  logic [RW_S-1:0] min_s, max_s;
`endif

  int errors = 0, checks = 0;
  int cyc = 0;
  int n_acc = 0, n_acc_s = 0;
  int acc_cyc[$];
  exp_t sb[$];
  exp_t sb_s[$];
  int ring_half = 15;
  int ready_mode = 1;
  bit watch_osc = 0, osc_dropped = 0;

  ring_osc_freq_meter #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(8), .RESULT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .ring_clk(ring_clk), .osc_en(osc_en),
    .start(start), .stop(stop), .continuous(continuous), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .result_sat(result_sat), .overrun(overrun)
`ifdef RING_FREQ_MINMAX_EN
    , .min_result(min_result), .max_result(max_result)
`endif
  );

  ring_osc_freq_meter #(.GATE_CYCLES(GATE_S), .SETTLE_CYCLES(SETTLE_S), .CNT_W(8), .RESULT_W(RW_S)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ring_clk(ring_s), .osc_en(osc_en_s),
    .start(start_s), .stop(1'b0), .continuous(1'b0), .busy(busy_s),
    .result_valid(result_valid_s), .result_ready(1'b1), .result(result_s),
    .result_sat(result_sat_s), .overrun(overrun_s)
`ifdef RING_FREQ_MINMAX_EN
    , .min_result(min_s), .max_result(max_s)
`endif
  );

  always #(CLK_P / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ring oscillators only toggle while the DUT enables them.
  initial begin
    #2;
    forever begin
      #(ring_half);
      if (osc_en) ring_clk = ~ring_clk;
      else ring_clk = 1'b0;
    end
  end

  initial begin
    #3;
    forever begin
      #10;
      if (osc_en_s) ring_s = ~ring_s;
      else ring_s = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: result_ready = 1'b0;
      1: result_ready = 1'b1;
      default: result_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: edges in a window = gate time / ring period, +-1 quantisation plus any extra slack.
  function automatic exp_t model(input int half, input int slack, input int gate, input int rw);
    exp_t e;
    real x, lim;
    x     = real'(gate * CLK_P) / (2.0 * real'(half));
    lim   = real'((1 << rw) - 1);
    e.sat = (x > lim);
    e.lo  = e.sat ? int'(lim) : $rtoi(x - 1.0 - real'(slack));
    e.hi  = e.sat ? int'(lim) : $rtoi(x + 1.0 + real'(slack));
    return e;
  endfunction

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d, required no result", result);
      end else begin
        e = sb.pop_front();
        chk_rng("result", result, e.lo, e.hi);
        chk("result_sat", result_sat, e.sat);
      end
      n_acc++;
      acc_cyc.push_back(cyc);
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && result_valid_s) begin
      if (sb_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sat_result: got %0d, required no result", result_s);
      end else begin
        e = sb_s.pop_front();
        chk_rng("sat_result", result_s, e.lo, e.hi);
        chk("sat_flag", result_sat_s, e.sat);
      end
      n_acc_s++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (watch_osc && !osc_en) osc_dropped = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (n_acc < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, (n_acc >= target), 1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_osc_en"}, osc_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_sat"}, result_sat, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int base, first, n;
    tick(3);
    chk_idle_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Single shots: first at ring = clk/3, then random ring periods and random consumer stalls.
    for (int i = 0; i < 5; i++) begin
      int lat;
      ring_half  = (i == 0) ? 15 : int'($urandom_range(6, 30));
      ready_mode = (i == 0) ? 1 : 2;
      sb.push_back(model(ring_half, 0, GATE, RW));
      base = n_acc;
      pulse_start();
      lat = 0;
      while (!result_valid && lat < 400) begin
        tick(1);
        lat++;
      end
      chk("latency", lat, SETTLE + GATE + 1);
      wait_acc(base + 1, 200, "single_accept");
      tick(2);
    end

    // Narrow accumulator saturates with ring = clk/2.
    sb_s.push_back('{63, 63, 1'b1});
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
    n = 0;
    while (n_acc_s < 1 && n < GATE_S + SETTLE_S + 20) begin
      tick(1);
      n++;
    end
    chk("sat_accept", n_acc_s, 1);

    // Continuous with an always-ready consumer.
    ring_half  = 15;
    ready_mode = 1;
    continuous = 1'b1;
    repeat (4) sb.push_back(model(15, 0, GATE, RW));
    base  = n_acc;
    first = acc_cyc.size();
    osc_dropped = 0;
    pulse_start();
    watch_osc = 1;
    wait_acc(base + 4, 4 * (GATE + 1) + SETTLE + 20, "cont_accepts");
    watch_osc  = 0;
    continuous = 1'b0;
    pulse_stop();
    for (int k = 0; k < 3; k++) begin
      chk("cont_period", acc_cyc[first+k+1] - acc_cyc[first+k], GATE + 1);
    end
    chk("cont_osc_steady", osc_dropped, 0);
    chk("cont_no_overrun", overrun, 0);

    // Stalled consumer across two windows; the second window runs at ring = clk/4.
    ready_mode = 0;
    continuous = 1'b1;
    sb.push_back(model(20, 2, GATE, RW));
    base = n_acc;
    pulse_start();
    n = 0;
    while (!result_valid && n < SETTLE + GATE + 20) begin
      tick(1);
      n++;
    end
    ring_half = 20;
    n = 0;
    while (!overrun && n < GATE + 20) begin
      tick(1);
      n++;
    end
    chk("overrun_set", overrun, 1);
    pulse_stop();
    continuous = 1'b0;
    chk("overrun_valid_held", result_valid, 1);
    ready_mode = 1;
    wait_acc(base + 1, 20, "overrun_accept");
    ring_half = 15;
    pulse_start();
    chk("overrun_cleared", overrun, 0);
    pulse_stop();
    tick(2);

    // Stop in the middle of a window.
    base = n_acc;
    pulse_start();
    tick(SETTLE + 50);
    pulse_stop();
    chk("stop_busy", busy, 0);
    chk("stop_osc_en", osc_en, 0);
    tick(GATE + SETTLE + 20);
    chk("stop_no_result", n_acc, base);
    chk("stop_valid", result_valid, 0);

    // Reset in the middle of a window.
    pulse_start();
    tick(SETTLE + 50);
    rst_n = 1'b0;
    tick(1);
    chk_idle_zero("midreset");
    rst_n = 1'b1;
    tick(GATE + SETTLE + 20);
    chk("midreset_no_result", n_acc, base);
    chk("midreset_busy", busy, 0);

`ifdef RING_FREQ_MINMAX_EN
    // Three back-to-back windows at ring periods 2x, 4x, 3x clk.
    continuous = 1'b1;
    ready_mode = 1;
    ring_half  = 10;
    sb.push_back(model(10, 2, GATE, RW));
    sb.push_back(model(20, 2, GATE, RW));
    sb.push_back(model(15, 2, GATE, RW));
    base = n_acc;
    pulse_start();
    wait_acc(base + 1, SETTLE + GATE + 20, "mm_w1");
    ring_half = 20;
    wait_acc(base + 2, GATE + 20, "mm_w2");
    ring_half = 15;
    wait_acc(base + 3, GATE + 20, "mm_w3");
    continuous = 1'b0;
    pulse_stop();
    chk_rng("min_result", min_result, 72, 78);
    chk_rng("max_result", max_result, 147, 153);
`endif

    tick(5);
    chk("scoreboard_drained", sb.size() + sb_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
